// File: rtl/decod_pkg.sv
// ---------------------------------------------------------------------------
// decod_pkg
// Shared constants and helpers for the registered one-hot decoder.
//   DECOD_IN_W   : default select width (output width is 2**DECOD_IN_W)
//   decod_out_w  : derives the one-hot output width from a select width
//   onehot0      : true when a vector has zero or exactly one bit set
// ---------------------------------------------------------------------------
package decod_pkg;

    localparam int DECOD_IN_W = 2;

    function automatic int decod_out_w(input int in_w);
        return 1 << in_w;
    endfunction

    // Clearing the lowest set bit leaves zero only when at most one bit was
    // set; the all-zero case wraps to all-ones and still ANDs to zero.
    function automatic logic onehot0(input logic [63:0] vec);
        return (vec & (vec - 64'd1)) == 64'd0;
    endfunction

endpackage

// File: rtl/decod_core.sv
// ---------------------------------------------------------------------------
// decod_core
// Purely combinational binary-to-one-hot decoder with active-high enable.
// Ports:
//   i_a [IN_W-1:0]   : binary select code
//   i_e              : decode enable
//   o_y [OUT_W-1:0]  : one-hot decode, all-zero when i_e is low
// ---------------------------------------------------------------------------
module decod_core #(
    parameter int IN_W  = 2,
    parameter int OUT_W = 4
) (
    input  logic [IN_W-1:0]  i_a,
    input  logic             i_e,
    output logic [OUT_W-1:0] o_y
);

    // One comparator per output line; each line fires only for its own code.
    for (genvar i = 0; i < OUT_W; i++) begin : g_line
        assign o_y[i] = i_e && (i_a == IN_W'(i));
    end

endmodule

// File: rtl/decoder.sv
// ---------------------------------------------------------------------------
// decoder
// Registered binary-to-one-hot decoder. Inputs are sampled on the rising
// clock edge and the one-hot word is driven straight from flops, so there
// is no combinational path from A/E to Y.
// Ports:
//   clk              : clock, rising-edge active
//   rst_n            : asynchronous active-low reset, clears Y (and err)
//   A   [IN_W-1:0]   : binary select code
//   E                : decode enable, active-high
//   Y   [OUT_W-1:0]  : registered one-hot decode
//   err              : sticky one-hot violation flag (only when
//                      DECOD_ONEHOT_CHK_EN is defined)
// Build option: DECOD_ONEHOT_CHK_EN adds the registered one-hot checker.
// ---------------------------------------------------------------------------
module decoder
    import decod_pkg::*;
#(
    parameter int IN_W = DECOD_IN_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [IN_W-1:0]              A,
    input  logic                         E,
    output logic [decod_out_w(IN_W)-1:0] Y
`ifdef DECOD_ONEHOT_CHK_EN
    ,
    output logic                         err
`endif
);

    localparam int OUT_W = decod_out_w(IN_W);

    logic [OUT_W-1:0] w_y_d;
    logic [OUT_W-1:0] r_y;

    decod_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .i_a (A),
        .i_e (E),
        .o_y (w_y_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y <= '0;
        end else begin
            r_y <= w_y_d;
        end
    end

    assign Y = r_y;

`ifdef DECOD_ONEHOT_CHK_EN
    logic r_err;

    // Checks the registered word, so a corrupted Y shows up one cycle later;
    // once raised, only reset clears the flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (!onehot0(64'(r_y))) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`endif

endmodule

// File: tb/tb_decoder.sv
// ---------------------------------------------------------------------------
// tb_decoder
// Self-checking bench for the registered one-hot decoder. Expected words
// come from a behavioural model (2**A when enabled, zero otherwise).
// ---------------------------------------------------------------------------
module tb_decoder;

    localparam int IN_W  = 2;
    localparam int OUT_W = 1 << IN_W;

    logic             clk;
    logic             rst_n;
    logic [IN_W-1:0]  A;
    logic             E;
    logic [OUT_W-1:0] Y;
`ifdef DECOD_ONEHOT_CHK_EN
    logic             err;
`endif

    int checkCount;
    int errorCount;

    decoder #(.IN_W(IN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .E     (E),
        .Y     (Y)
`ifdef DECOD_ONEHOT_CHK_EN
        ,
        .err   (err)
`endif
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural reference: the enabled line is worth 2**A.
    function automatic logic [63:0] modelY(input int a, input bit e);
        if (!e) return 64'd0;
        return 64'(2 ** a);
    endfunction

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Drive inputs on the falling edge, then check Y just after the next
    // rising edge against the model.
    task automatic applyStimulus(input int a, input bit e, input string tag);
        @(negedge clk);
        A = IN_W'(a);
        E = e;
        @(posedge clk);
        #1;
        checkOutput(tag, 64'(Y), modelY(a, e));
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;

        // Reset held low with an active decode request.
        rst_n = 1'b0;
        A     = 2'b11;
        E     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_hold_Y", 64'(Y), 64'd0);
`ifdef DECOD_ONEHOT_CHK_EN
        checkOutput("reset_hold_err", 64'(err), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("reset_release_Y", 64'(Y), 64'b1000);

        // Enable gating.
        applyStimulus(0, 1'b0, "gate_off_1");
        applyStimulus(0, 1'b0, "gate_off_2");
        applyStimulus(0, 1'b1, "gate_on");

        // Directed sequence, each code held two cycles.
        applyStimulus(1, 1'b1, "seq_01_a");
        applyStimulus(1, 1'b1, "seq_01_b");
        applyStimulus(3, 1'b1, "seq_11_a");
        applyStimulus(3, 1'b1, "seq_11_b");
        applyStimulus(2, 1'b1, "seq_10_a");
        applyStimulus(2, 1'b1, "seq_10_b");

        // Mid-cycle glitch on A must not reach Y.
        applyStimulus(0, 1'b1, "glitch_setup");
        #2 A = 2'b11;
        #2 A = 2'b00;
        #1;
        checkOutput("glitch_hold", 64'(Y), 64'b0001);

        // Asynchronous reset between edges, then reload from new inputs.
        applyStimulus(2, 1'b1, "async_setup");
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_clear", 64'(Y), 64'd0);
        A = 2'b01;
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("async_reload", 64'(Y), 64'b0010);

        // Randomised run against the model, including simultaneous A/E changes.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(int'($urandom_range(0, OUT_W - 1)), bit'($urandom_range(0, 1)), "random");
        end

`ifdef DECOD_ONEHOT_CHK_EN
        // Exhaustive A x E sweep keeps the checker quiet.
        for (int e = 0; e < 2; e++) begin
            for (int a = 0; a < OUT_W; a++) begin
                applyStimulus(a, bit'(e), "sweep_Y");
                checkOutput("sweep_err", 64'(err), 64'd0);
            end
        end

        // Corrupt the output register and expect a sticky flag.
        @(negedge clk);
        A = 2'b00;
        E = 1'b1;
        force dut.r_y = 4'b0110;
        @(posedge clk);
        #1;
        release dut.r_y;
        checkOutput("force_err", 64'(err), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("sticky_err", 64'(err), 64'd1);
        checkOutput("force_recover_Y", 64'(Y), 64'b0001);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("err_reset", 64'(err), 64'd0);
        rst_n = 1'b1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
